// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the junction lamp logic
//
// Purpose: lane-count constants and the lamp sequencer state encoding,
// shared by lane_light_driver and lane_decoder.
// Ports: none (package).
package traffic_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALL_RED = 2'd1,
    GREEN   = 2'd2,
    YELLOW  = 2'd3
  } state_t;

endpackage

// File: rtl/lane_decoder.sv
// rtl/lane_decoder.sv - combinational lane index to one-hot lamp mask
//
// Purpose: turns a lane index into a one-hot mask used for both the green
// and the yellow lamp vectors.
// Ports:
//   lane    in  LANE_W     lane index
//   onehot  out NUM_LANES  bit[lane] set, all others clear
module lane_decoder
  import traffic_pkg::*;
(
  input  logic [LANE_W-1:0]    lane,
  output logic [NUM_LANES-1:0] onehot
);

  always_comb begin
    onehot       = '0;
    onehot[lane] = 1'b1;
  end

endmodule

// File: rtl/lane_light_driver.sv
// rtl/lane_light_driver.sv - 4-lane red/yellow/green lamp sequencer
//
// Purpose: follows the requested lane index from the lane counter and
// drives per-lane lamps, inserting a yellow phase on the outgoing lane and
// an all-red clearance before the next green. Both phases are timed in
// tick pulses.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   tick         in   one-cycle 1 s enable pulse
//   lights_en    in   1 = sequence normally, 0 = force all-red idle
//   lane_sel     in   requested green lane, 0..3
//   red          out  per-lane red lamp (bit i = lane i)
//   yellow       out  per-lane yellow lamp
//   green        out  per-lane green lamp
//   active_lane  out  lane currently or most recently granted green
//   busy         out  high while in YELLOW or ALL_RED
module lane_light_driver
  import traffic_pkg::*;
#(
  parameter int YELLOW_TICKS  = 3,
  parameter int ALL_RED_TICKS = 2,
  parameter int CNT_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 lights_en,
  input  logic [LANE_W-1:0]    lane_sel,
  output logic [NUM_LANES-1:0] red,
  output logic [NUM_LANES-1:0] yellow,
  output logic [NUM_LANES-1:0] green,
  output logic [LANE_W-1:0]    active_lane,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALL_RED_LAST = CNT_W'(ALL_RED_TICKS - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [LANE_W-1:0]      lane_d;
  logic [NUM_LANES-1:0]   lane_mask;
  logic [NUM_LANES-1:0]   red_d;
  logic [NUM_LANES-1:0]   yellow_d;
  logic [NUM_LANES-1:0]   green_d;
  logic                   busy_d;

  // Next-state logic. lights_en low overrides every state; active_lane
  // only changes at the ALL_RED exit, so it holds through IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = active_lane;
    if (!lights_en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A tick in the enabling cycle is deliberately not counted.
          state_d = ALL_RED;
          cnt_d   = '0;
        end
        ALL_RED: begin
          if (tick) begin
            if (cnt_q == ALL_RED_LAST) begin
              state_d = GREEN;
              cnt_d   = '0;
              lane_d  = lane_sel;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        GREEN: begin
          cnt_d = '0;
          if (lane_sel != active_lane) begin
            state_d = YELLOW;
          end
        end
        YELLOW: begin
          // lane_sel is ignored here; the transition always runs to the end.
          if (tick) begin
            if (cnt_q == YELLOW_LAST) begin
              state_d = ALL_RED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  lane_decoder u_lane_decoder (
    .lane   (lane_d),
    .onehot (lane_mask)
  );

  // Lamps are decoded from the next state so the registered outputs show the
  // new state in the cycle right after the transition condition.
  always_comb begin
    green_d  = (state_d == GREEN)  ? lane_mask : '0;
    yellow_d = (state_d == YELLOW) ? lane_mask : '0;
    red_d    = ~(green_d | yellow_d);
    busy_d   = (state_d == YELLOW) || (state_d == ALL_RED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      active_lane <= '0;
      red         <= '1;
      yellow      <= '0;
      green       <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_lane <= lane_d;
      red         <= red_d;
      yellow      <= yellow_d;
      green       <= green_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_lane_light_driver.sv
// tb/tb_lane_light_driver.sv - scoreboard bench for lane_light_driver
module tb_lane_light_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       lights_en;
  logic [1:0] lane_sel;
  logic [3:0] red;
  logic [3:0] yellow;
  logic [3:0] green;
  logic [1:0] active_lane;
  logic       busy;

  lane_light_driver #(
    .YELLOW_TICKS  (3),
    .ALL_RED_TICKS (2),
    .CNT_W         (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .lights_en   (lights_en),
    .lane_sel    (lane_sel),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .active_lane (active_lane),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r;
    logic [3:0] y;
    logic [3:0] g;
    logic [1:0] al;
    logic       b;
    int         t;   // ticks seen in the previous lamp state, -1 = don't care
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;

  task automatic expect_ev(input string name, input logic [3:0] r, input logic [3:0] y,
                           input logic [3:0] g, input logic [1:0] al, input logic b,
                           input int t);
    exp_t e;
    e.r = r; e.y = y; e.g = g; e.al = al; e.b = b; e.t = t; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: an output event is any change of the registered outputs.
  logic [3:0] p_r, p_y, p_g;
  logic [1:0] p_al;
  logic       p_b;
  int         tcnt = 0;

  always @(negedge clk) begin
    exp_t e;
    int   nonred;
    logic ok;
    // One-lamp-per-lane invariant, every cycle.
    ok = 1'b1;
    nonred = 0;
    for (int i = 0; i < 4; i++) begin
      if ((red[i] + yellow[i] + green[i]) != 2'd1) ok = 1'b0;
      if (!red[i]) nonred++;
    end
    if (nonred > 1) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL invariant: actual r=%b y=%b g=%b required one lamp per lane, <=1 non-red",
               red, yellow, green);
    end
    if (!mon_en) begin
      tcnt = 0;
    end else if ({red, yellow, green, active_lane, busy} != {p_r, p_y, p_g, p_al, p_b}) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: actual r=%b y=%b g=%b al=%0d busy=%b required no change",
                 red, yellow, green, active_lane, busy);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (red !== e.r || yellow !== e.y || green !== e.g || active_lane !== e.al ||
            busy !== e.b || (e.t >= 0 && tcnt != e.t)) begin
          failures++;
          $display("FAIL %s: actual r=%b y=%b g=%b al=%0d busy=%b ticks=%0d required r=%b y=%b g=%b al=%0d busy=%b ticks=%0d",
                   e.name, red, yellow, green, active_lane, busy, tcnt,
                   e.r, e.y, e.g, e.al, e.b, e.t);
        end
      end
      tcnt = 0;
    end
    if (mon_en && tick) tcnt++;
    p_r = red; p_y = yellow; p_g = green; p_al = active_lane; p_b = busy;
  end

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (9) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  endtask

  task automatic set_lane(input logic [1:0] l);
    @(posedge clk);
    #1 lane_sel = l;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: actual pending=%0d required pending=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; lights_en = 1'b0; lane_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_val("reset_red", red, 4'b1111);
    check_val("reset_yellow", yellow, 0);
    check_val("reset_green", green, 0);
    check_val("reset_active_lane", active_lane, 0);
    check_val("reset_busy", busy, 0);
    @(posedge clk);
    #1 mon_en = 1'b1;

    // 1: enable, two all-red ticks, then green on lane 0
    expect_ev("t1_allred", 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b1, -1);
    expect_ev("t1_green0", 4'b1110, 4'b0000, 4'b0001, 2'd0, 1'b0, 2);
    lights_en = 1'b1;
    ticks(2);
    drain("t1");

    // 2: lane 0 -> lane 1
    expect_ev("t2_yellow0", 4'b1110, 4'b0001, 4'b0000, 2'd0, 1'b1, 0);
    expect_ev("t2_allred", 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b1, 3);
    expect_ev("t2_green1", 4'b1101, 4'b0000, 4'b0010, 2'd1, 1'b0, 2);
    set_lane(2'd1);
    ticks(5);
    drain("t2");

    // 3: request changes 0 then 3 during yellow, no restart
    expect_ev("t3_yellow1", 4'b1101, 4'b0010, 4'b0000, 2'd1, 1'b1, 0);
    expect_ev("t3_allred", 4'b1111, 4'b0000, 4'b0000, 2'd1, 1'b1, 3);
    expect_ev("t3_green3", 4'b0111, 4'b0000, 4'b1000, 2'd3, 1'b0, 2);
    set_lane(2'd0);
    ticks(1);
    set_lane(2'd3);
    ticks(4);
    drain("t3");

    // 4: reach lane 2, then 2->3->2 during yellow regains lane 2
    expect_ev("t4_yellow3", 4'b0111, 4'b1000, 4'b0000, 2'd3, 1'b1, 0);
    expect_ev("t4_allred_a", 4'b1111, 4'b0000, 4'b0000, 2'd3, 1'b1, 3);
    expect_ev("t4_green2_a", 4'b1011, 4'b0000, 4'b0100, 2'd2, 1'b0, 2);
    set_lane(2'd2);
    ticks(5);
    drain("t4a");
    expect_ev("t4_yellow2", 4'b1011, 4'b0100, 4'b0000, 2'd2, 1'b1, 0);
    expect_ev("t4_allred_b", 4'b1111, 4'b0000, 4'b0000, 2'd2, 1'b1, 3);
    expect_ev("t4_green2_b", 4'b1011, 4'b0000, 4'b0100, 2'd2, 1'b0, 2);
    set_lane(2'd3);
    ticks(1);
    set_lane(2'd2);
    ticks(4);
    drain("t4b");

    // 5: disable mid-yellow, re-enable in the same cycle as a tick
    expect_ev("t5_yellow2", 4'b1011, 4'b0100, 4'b0000, 2'd2, 1'b1, 0);
    expect_ev("t5_idle", 4'b1111, 4'b0000, 4'b0000, 2'd2, 1'b0, 1);
    expect_ev("t5_allred", 4'b1111, 4'b0000, 4'b0000, 2'd2, 1'b1, 1);
    expect_ev("t5_green1", 4'b1101, 4'b0000, 4'b0010, 2'd1, 1'b0, 2);
    set_lane(2'd0);
    ticks(1);
    lights_en = 1'b0;
    set_lane(2'd1);
    repeat (9) @(posedge clk);
    #1 tick = 1'b1; lights_en = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    ticks(2);
    drain("t5");

    // 6: asynchronous reset mid-ALL_RED
    expect_ev("t6_yellow1", 4'b1101, 4'b0010, 4'b0000, 2'd1, 1'b1, 0);
    expect_ev("t6_allred", 4'b1111, 4'b0000, 4'b0000, 2'd1, 1'b1, 3);
    set_lane(2'd2);
    ticks(3);
    drain("t6");
    ticks(1);
    @(posedge clk);
    #3 mon_en = 1'b0; rst_n = 1'b0;
    #1;
    check_val("async_red", red, 4'b1111);
    check_val("async_yellow", yellow, 0);
    check_val("async_green", green, 0);
    check_val("async_active_lane", active_lane, 0);
    check_val("async_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; lights_en = 1'b0;
    repeat (3) @(posedge clk);
    check_val("leftover_events", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
